pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 tb/tb_pipe_stage_reg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, a registered
// in_ready and a synchronous flush. Optional stall counter: PIPE_STAGE_STALL_CNT_EN.
`timescale 1ns/1ps

module pipe_stage_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // Encoding is {main_v, skid_v}; 2'b01 has no name and must never occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_v;
  logic             skid_v;
  logic             acc;
  logic             drn;

  assign main_v    = state[1];
  assign skid_v    = state[0];
  assign acc       = in_valid & in_ready;
  assign drn       = main_v & out_ready;
  assign out_valid = main_v;
  assign out_data  = main_v ? main_data : RST_VALUE;

  // in_ready is written alongside the state so it always equals !(state == SKID).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      main_data <= RST_VALUE;
      skid_data <= RST_VALUE;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      main_data <= RST_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_data <= in_data;
            state     <= FULL;
          end
        end
        FULL: begin
          if (acc && drn) begin
            main_data <= in_data;
          end else if (acc) begin
            skid_data <= in_data;
            state     <= SKID;
            in_ready  <= 1'b0;
          end else if (drn) begin
            state     <= EMPTY;
          end
        end
        SKID: begin
          if (drn) begin
            main_data <= skid_data;
            state     <= FULL;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
    end else if (flush) begin
      stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

  a_no_orphan_skid : assert property (@(posedge clk) disable iff (!rst) !(skid_v && !main_v));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector table plus async-reset, random scoreboard and (optional)
// stall-counter sequences for pipe_stage_reg.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        rdy;
    logic        fl;
    logic        exp_ov;
    logic        exp_ir;
    logic [31:0] exp_od;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  pipe_stage_reg #(.WIDTH(32), .RST_VALUE(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic rdy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[23];
  int   q[$];

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // stream 1..8 at full rate, then a final drain
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 32'(i + 1), 1'b1, 1'b0, 1'b1, 1'b1, 32'(i + 1)};
    vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, RV};
    // fill to SKID under stall, offer a beat while not ready, then drain in order
    vecs[9]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA};
    vecs[10] = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA};
    vecs[11] = '{1'b1, 32'hF,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA};
    vecs[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB};
    vecs[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, RV};
    // flush in SKID with a beat offered: everything squashed
    vecs[14] = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA};
    vecs[15] = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA};
    vecs[16] = '{1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 1'b1, RV};
    vecs[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, RV};
    // flush in FULL with accept and drain in the same cycle
    vecs[18] = '{1'b1, 32'h5,  1'b0, 1'b0, 1'b1, 1'b1, 32'h5};
    vecs[19] = '{1'b1, 32'h6,  1'b1, 1'b1, 1'b0, 1'b1, RV};
    // hold under stall, then drain
    vecs[20] = '{1'b1, 32'h7,  1'b1, 1'b0, 1'b1, 1'b1, 32'h7};
    vecs[21] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h7};
    vecs[22] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, RV};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset in_ready",  {31'h0, in_ready},  32'h1);
    checkOutput("reset out_data",  out_data,           RV);
    rst = 1'b1;
    #1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].fl);
      checkOutput($sformatf("vec%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_ov});
      checkOutput($sformatf("vec%0d in_ready", i),  {31'h0, in_ready},  {31'h0, vecs[i].exp_ir});
      checkOutput($sformatf("vec%0d out_data", i),  out_data,           vecs[i].exp_od);
    end

    // asynchronous reset asserted mid-cycle while in SKID
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
    checkOutput("pre-async in_ready", {31'h0, in_ready}, 32'h0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("async out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("async in_ready",  {31'h0, in_ready},  32'h1);
    checkOutput("async out_data",  out_data,           RV);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // random traffic against a FIFO scoreboard; occupancy predicts both flags
    begin
      int rfails = 0;
      for (int c = 0; c < 10000 && rfails < 20; c++) begin
        logic iv, rdy, fl, acc, drn, ok;
        logic [31:0] d;
        ok = (out_valid === (q.size() > 0)) && (in_ready === (q.size() < 2));
        if (ok && q.size() > 0) ok = (out_data === q[0]);
        tests++;
        if (!ok) begin
          fails++;
          rfails++;
          $display("[TB] FAIL random cycle %0d: got v=%b r=%b d=%h, expected v=%b r=%b d=%h",
                   c, out_valid, in_ready, out_data, q.size() > 0, q.size() < 2,
                   (q.size() > 0) ? q[0] : RV);
        end
        iv  = 1'($urandom_range(0, 1));
        rdy = 1'($urandom_range(0, 1));
        fl  = ($urandom_range(0, 63) == 0);
        d   = $urandom;
        acc = iv && (q.size() < 2);
        drn = rdy && (q.size() > 0);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(d);
        if (fl) q.delete();
        applyStimulus(iv, d, rdy, fl);
      end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall after flush", {16'h0, stall_cnt}, 32'h0);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
    checkOutput("stall at accept", {16'h0, stall_cnt}, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall after 3", {16'h0, stall_cnt}, 32'h3);
    for (int i = 0; i < 70000; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall saturated", {16'h0, stall_cnt}, 32'h0000FFFF);
    checkOutput("stall held data", out_data, 32'h33);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall cleared", {16'h0, stall_cnt}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
